// File: rtl/rst_release_seq.sv
// rst_release_seq: asserts NUM_STAGES active-low reset domains asynchronously, releases them in order synchronously to CLK
// Ports: CLK rising-edge clock; R async active-low reset; sw_req synchronous soft reset request (level)
//        rst_n_out sequenced active-low resets, bit 0 first; stage_idx count of released stages
//        seq_busy high while any stage is held; seq_done high once every stage is released
module rst_release_seq #(
  parameter int NUM_STAGES  = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYCLES = 8,
  parameter int GAP_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic                               CLK,
  input  logic                               R,
  input  logic                               sw_req,
  output logic [NUM_STAGES-1:0]              rst_n_out,
  output logic [$clog2(NUM_STAGES+1)-1:0]    stage_idx,
  output logic                               seq_busy,
  output logic                               seq_done
);
  localparam int IW = $clog2(NUM_STAGES + 1);
  localparam logic [NUM_STAGES-1:0] LSB = NUM_STAGES'(1);
  typedef enum logic [1:0] {HOLD, GAP, DONE} state_t;
  state_t               r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0]     r_cnt;
  logic                 w_rst_sync;
  logic                 w_last;
  assign w_rst_sync = r_sync[SYNC_STAGES-1];
  assign w_last     = stage_idx == IW'(NUM_STAGES - 1);
  always_ff @(posedge CLK or negedge R)
    if (!R) r_sync <= '0;
    else    r_sync <= {r_sync[SYNC_STAGES-2:0], 1'b1};
  // Outputs are flops only: they feed async pins downstream and must not glitch.
  always_ff @(posedge CLK or negedge R)
    if (!R) begin
      r_state   <= HOLD;
      r_cnt     <= '0;
      rst_n_out <= '0;
      stage_idx <= '0;
      seq_busy  <= 1'b1;
      seq_done  <= 1'b0;
    end else if (w_rst_sync) begin
      if (sw_req) begin
        r_state   <= HOLD;
        r_cnt     <= '0;
        rst_n_out <= '0;
        stage_idx <= '0;
        seq_busy  <= 1'b1;
        seq_done  <= 1'b0;
      end else begin
        case (r_state)
          HOLD:
            if (r_cnt == CNT_W'(HOLD_CYCLES - 1)) begin
              r_cnt     <= '0;
              rst_n_out <= LSB;
              stage_idx <= IW'(1);
              r_state   <= (NUM_STAGES == 1) ? DONE : GAP;
              seq_busy  <= NUM_STAGES != 1;
              seq_done  <= NUM_STAGES == 1;
            end else r_cnt <= r_cnt + 1'b1;
          GAP:
            if (r_cnt == CNT_W'(GAP_CYCLES - 1)) begin
              r_cnt     <= '0;
              // rst_n_out is a thermometer code, so releasing the next bit is a shift-in of 1
              rst_n_out <= (rst_n_out << 1) | LSB;
              stage_idx <= stage_idx + 1'b1;
              r_state   <= w_last ? DONE : GAP;
              seq_busy  <= !w_last;
              seq_done  <= w_last;
            end else r_cnt <= r_cnt + 1'b1;
          default: ;
        endcase
      end
    end
endmodule

// File: tb/tb_rst_release_seq.sv
// tb_rst_release_seq: table, directed and random checks of rst_release_seq against a release-time model
module tb_rst_release_seq;
  localparam int SYNC = 2;
  logic CLK = 1'b0;
  logic R = 1'b1;
  logic sw_req = 1'b0;
  logic [3:0] o0_rst; logic [2:0] o0_idx; logic o0_busy, o0_done;
  logic [0:0] o1_rst; logic [0:0] o1_idx; logic o1_busy, o1_done;
  logic [2:0] o2_rst; logic [1:0] o2_idx; logic o2_busy, o2_done;
  int errs = 0;
  int checks = 0;
  int n = 0;
  int start = SYNC;
  typedef struct { int e; int r0; int r1; int r2; } vec_t;
  vec_t tbl [12];

  rst_release_seq d0 (.CLK(CLK), .R(R), .sw_req(sw_req), .rst_n_out(o0_rst), .stage_idx(o0_idx), .seq_busy(o0_busy), .seq_done(o0_done));
  rst_release_seq #(.NUM_STAGES(1), .HOLD_CYCLES(1), .GAP_CYCLES(1)) d1 (.CLK(CLK), .R(R), .sw_req(sw_req), .rst_n_out(o1_rst), .stage_idx(o1_idx), .seq_busy(o1_busy), .seq_done(o1_done));
  rst_release_seq #(.NUM_STAGES(3), .HOLD_CYCLES(1), .GAP_CYCLES(1)) d2 (.CLK(CLK), .R(R), .sw_req(sw_req), .rst_n_out(o2_rst), .stage_idx(o2_idx), .seq_busy(o2_busy), .seq_done(o2_done));

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, exp);
    end
  endtask

  // Released stage count from elapsed edges since counting began: nothing for the hold period, then one per gap.
  function automatic int rel(int h, int g, int ns);
    int e = n - start;
    if (e < h) return 0;
    return (1 + (e - h) / g > ns) ? ns : 1 + (e - h) / g;
  endfunction

  task automatic check_model();
    int r;
    r = rel(8, 4, 4);
    chk("d0_rst", int'(o0_rst), (1 << r) - 1); chk("d0_idx", int'(o0_idx), r);
    chk("d0_busy", int'(o0_busy), int'(r < 4)); chk("d0_done", int'(o0_done), int'(r == 4));
    r = rel(1, 1, 1);
    chk("d1_rst", int'(o1_rst), (1 << r) - 1); chk("d1_idx", int'(o1_idx), r);
    chk("d1_busy", int'(o1_busy), int'(r < 1)); chk("d1_done", int'(o1_done), int'(r == 1));
    r = rel(1, 1, 3);
    chk("d2_rst", int'(o2_rst), (1 << r) - 1); chk("d2_idx", int'(o2_idx), r);
    chk("d2_busy", int'(o2_busy), int'(r < 3)); chk("d2_done", int'(o2_done), int'(r == 3));
  endtask

  task automatic tick();
    @(posedge CLK);
    if (R) begin
      n++;
      if (sw_req && n > SYNC) start = n;
    end
    #1;
    check_model();
  endtask

  task automatic drop_r();
    R = 1'b0;
    n = 0;
    start = SYNC;
    #1;
    check_model();
  endtask

  task automatic run_to(input int e);
    for (int k = 0; k < 200 && n < e; k++) tick();
  endtask

  task automatic restart();
    drop_r();
    tick(); tick();
    R = 1'b1;
  endtask

  initial begin
    tbl[0]  = '{2, 0, 0, 0};  tbl[1]  = '{3, 0, 1, 1};  tbl[2]  = '{4, 0, 1, 3};
    tbl[3]  = '{5, 0, 1, 7};  tbl[4]  = '{9, 0, 1, 7};  tbl[5]  = '{10, 1, 1, 7};
    tbl[6]  = '{13, 1, 1, 7}; tbl[7]  = '{14, 3, 1, 7}; tbl[8]  = '{17, 3, 1, 7};
    tbl[9]  = '{18, 7, 1, 7}; tbl[10] = '{21, 7, 1, 7}; tbl[11] = '{22, 15, 1, 7};
    #2;
    drop_r();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pwr_low_rst", int'(o0_rst), 0);
      chk("pwr_low_busy", int'(o0_busy), 1);
    end
    R = 1'b1;
    foreach (tbl[i]) begin
      run_to(tbl[i].e);
      chk("tbl_d0_rst", int'(o0_rst), tbl[i].r0);
      chk("tbl_d1_rst", int'(o1_rst), tbl[i].r1);
      chk("tbl_d2_rst", int'(o2_rst), tbl[i].r2);
      chk("tbl_d0_done", int'(o0_done), int'(tbl[i].r0 == 15));
      chk("tbl_d0_busy", int'(o0_busy), int'(tbl[i].r0 != 15));
    end
    run_to(25);
    R = 1'b0;
    #2;
    chk("async_rst", int'(o0_rst), 0);
    chk("async_done", int'(o0_done), 0);
    chk("async_busy", int'(o0_busy), 1);
    n = 0; start = SYNC;
    tick(); tick();
    R = 1'b1;
    run_to(9);  chk("rerel_e9", int'(o0_rst), 0);
    run_to(10); chk("rerel_e10", int'(o0_rst), 1);
    run_to(22); chk("rerel_e22", int'(o0_rst), 15); chk("rerel_done", int'(o0_done), 1);
    restart();
    run_to(15); chk("swp_e15", int'(o0_rst), 3);
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    chk("swp_e16_rst", int'(o0_rst), 0); chk("swp_e16_idx", int'(o0_idx), 0);
    run_to(23); chk("swp_e23", int'(o0_rst), 0);
    run_to(24); chk("swp_e24", int'(o0_rst), 1);
    run_to(35); chk("swp_e35", int'(o0_rst), 7);
    run_to(36); chk("swp_e36", int'(o0_rst), 15); chk("swp_done", int'(o0_done), 1);
    run_to(40);
    sw_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("swh_rst", int'(o0_rst), 0);
    end
    sw_req = 1'b0;
    run_to(52); chk("swh_e52", int'(o0_rst), 0);
    run_to(53); chk("swh_e53", int'(o0_rst), 1);
    restart();
    sw_req = 1'b1; tick(); sw_req = 1'b0;
    run_to(9);  chk("swign_e9", int'(o0_rst), 0);
    run_to(10); chk("swign_e10", int'(o0_rst), 1);
    run_to(22); chk("swign_e22", int'(o0_rst), 15);
    for (int i = 0; i < 600; i++) begin
      sw_req = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 79) == 0) begin
        sw_req = 1'b0;
        drop_r();
        for (int k = $urandom_range(1, 2); k > 0; k--) tick();
        R = 1'b1;
      end
      tick();
    end
    sw_req = 1'b0;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/rst_release_seq.md
Name: rst_release_seq

Overview:
- Reset generator that produces the active-low asynchronous clear/preset nets for downstream flops with async set/reset, such as the DFFSR cells.
- Asserts all outputs asynchronously and releases them synchronously to CLK. This satisfies recovery/removal timing at the receiving flops.
- Releases NUM_STAGES reset domains one after another, with programmable hold and gap times.
- Sits at the top of the SoC, between the pad reset / software reset request and the flop R/S nets.

Parameters:
- NUM_STAGES, 4: number of sequenced reset outputs; must be >= 1.
- SYNC_STAGES, 2: depth of the reset-release synchronizer chain; must be >= 2.
- HOLD_CYCLES, 8: cycles all outputs stay asserted after the synchronized release; must be >= 1.
- GAP_CYCLES, 4: cycles between successive stage releases; must be >= 1.
- CNT_W, 8: width of the hold/gap counter; must hold max(HOLD_CYCLES, GAP_CYCLES)-1.

Ports:
- CLK  input  1  single clock, rising-edge.
- R  input  1  reset, asynchronous and active-low.
- sw_req  input  1  synchronous software reset request, level, active-high.
- rst_n_out  output  NUM_STAGES  active-low resets; bit 0 releases first.
- stage_idx  output  $clog2(NUM_STAGES+1)  number of stages currently released.
- seq_busy  output  1  high while any rst_n_out bit is 0.
- seq_done  output  1  high when all stages are released.

Behaviour:
- One clock domain, CLK. All state and outputs are flops cleared asynchronously by R low. No combinational path to outputs (they drive async pins, so must be glitch-free).
- Values while R is low:
  - sync chain all 0; state HOLD; counter 0.
  - rst_n_out all 0; stage_idx 0; seq_busy 1; seq_done 0.
  - Outputs fall without needing a clock edge.
- Release synchronizer:
  - After R rises, the chain shifts in 1 each CLK edge.
  - rst_sync goes high on edge number SYNC_STAGES after release, with edges counted from 1.
  - While rst_sync is 0, the FSM is frozen in HOLD with counter 0.
- HOLD state:
  - Counter increments each edge while rst_sync=1.
  - On the edge after counter==HOLD_CYCLES-1: rst_n_out[0]<=1, stage_idx<=1, counter<=0.
  - If NUM_STAGES==1 go to DONE; else go to GAP.
- GAP state:
  - Counter increments each edge.
  - On the edge after counter==GAP_CYCLES-1: release bit stage_idx, stage_idx++, counter<=0.
  - When the last bit is released, go to DONE on that same edge.
- DONE state:
  - seq_busy<=0 and seq_done<=1 on the same edge as the final release.
  - Remains in DONE until R low or sw_req.
- Latency with R release at edge 0:
  - rst_n_out[k] rises at edge SYNC_STAGES + HOLD_CYCLES + k*GAP_CYCLES.
  - Defaults: bit0 at edge 10, bit1 at 14, bit2 at 18, bit3 and seq_done at 22.
- Release order is strictly monotonic: a released bit never re-asserts except via R or sw_req. Bits are never released out of order.
- sw_req:
  - Sampled only when rst_sync=1.
  - Any state, on the next edge: rst_n_out all 0, stage_idx 0, seq_busy 1, seq_done 0, state HOLD, counter 0.
  - Held high, it keeps the block in HOLD with counter 0. The hold count starts on the first edge with sw_req low.
  - Mid-sequence requests abort the sequence and restart from stage 0.
- Priority: R low > sw_req > hold/gap counting.
- R low mid-sequence or in DONE: immediate async return to the reset values. The sync chain is cleared, so the full SYNC_STAGES + HOLD_CYCLES latency applies again.
- Counter never exceeds the terminal value for the current state; no wrap-around occurs.

Test Plan:
- Power-up, defaults: R low for 3 cycles, then high. All outputs 0 while R low. Bits rise 0x1, 0x3, 0x7, 0xF at edges 10/14/18/22. seq_done=1 and seq_busy=0 at edge 22.
- Async assert: in DONE, drop R between clock edges. rst_n_out==0 and seq_done==0 before the next CLK edge. Re-release repeats the edge-10..22 timing.
- sw_req pulse mid-sequence: 1-cycle sw_req at edge 15 (rst_n_out=0x3). At edge 16 outputs are 0x0 and stage_idx=0. bit0 rises at edge 24, bit3 at edge 36.
- sw_req held 5 cycles from DONE: outputs stay 0 throughout. bit0 rises HOLD_CYCLES=8 edges after the first edge with sw_req low.
- sw_req while rst_sync=0: assert sw_req at edge 1 after R release. It is ignored; timing is identical to the power-up case.
- Corner parameters NUM_STAGES=1, HOLD_CYCLES=1, GAP_CYCLES=1, SYNC_STAGES=2: bit0 and seq_done rise at edge 3. NUM_STAGES=3 with GAP_CYCLES=1: bits rise on consecutive edges 3/4/5.
